// File: rtl/bcd4_stopwatch_pkg.sv
// Shared types and constants for the four-digit BCD stopwatch.
package bcd4_stopwatch_pkg;

   localparam int unsigned BCD_W = 4;
   localparam int unsigned NDIG  = 4;

   typedef logic [BCD_W-1:0] digit_t;

   localparam digit_t BCD_MAX = digit_t'(9);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_e;

   // Decimal increment of one digit; returns {carry_out, next_digit}.
   function automatic logic [BCD_W:0] bcd_inc(input digit_t d);
      if (d >= BCD_MAX) begin
         return {1'b1, digit_t'(0)};
      end
      return {1'b0, d + digit_t'(1)};
   endfunction

endpackage

// File: rtl/bcd4_stopwatch_key_debounce.sv
// Raw active-low key -> 2-FF synchronizer -> debouncer -> one-cycle press pulse.
module key_debounce
   import bcd4_stopwatch_pkg::*;
#(
   parameter int unsigned DEB_CYC = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic key_n_i,
   output logic press_o
);

   localparam int unsigned CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

   logic [1:0]    sync_q;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          press_q, press_d;
   logic          key_s;

   assign key_s   = sync_q[1];
   assign press_o = press_q;

   // Two-stage synchronizer, idles at the released level.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], key_n_i};
      end
   end

   // Count consecutive cycles the synchronized key disagrees with the accepted
   // level; accept it once the run reaches DEB_CYC. Only a press (1->0) pulses.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      press_d = 1'b0;
      if (key_s != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = key_s;
            press_d = ~key_s;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Debounce state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         level_q <= 1'b1;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         level_q <= level_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

endmodule

// File: rtl/bcd4_stopwatch.sv
// Four-digit BCD stopwatch: debounced start/stop and clear keys, IDLE/RUN/PAUSE
// control, tick prescaler, decimal digit chain with sticky wrap flag and a
// combinational digit select for a scanned display.
module bcd4_stopwatch
   import bcd4_stopwatch_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 50_000_000,
   parameter int unsigned TICK_HZ = 10,
   parameter int unsigned DEB_MS  = 20
) (
   input  logic        clk1,
   input  logic        rst_n,
   input  logic        btn_ss_n,
   input  logic        btn_clr_n,
   input  logic [1:0]  sel,
   output logic [3:0]  digit_out,
   output logic [15:0] bcd_out,
   output logic        run,
   output logic        ovf
);

   localparam int unsigned DEB_CYC = (CLK_HZ / 1000) * DEB_MS;
   localparam int unsigned PRESC_N = CLK_HZ / TICK_HZ;
   localparam int unsigned PW      = (PRESC_N > 1) ? $clog2(PRESC_N) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_N - 1);

   logic [1:0] rst_sync_q;
   logic       rst_s_n;
   logic       ss_p, clr_p;

   state_e     state_q, state_d;
   logic       clear_all, presc_zero, count_en, run_d;

   logic [PW-1:0] presc_q, presc_d;
   logic          tick;

   logic [NDIG-1:0][BCD_W-1:0] digits_q, digits_d;
   logic       carry;
   logic       ovf_q, ovf_d;
   logic       run_q;

   // Reset synchronizer: asserts immediately, releases two clk1 edges later.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_s_n = rst_sync_q[1];

   key_debounce #(.DEB_CYC(DEB_CYC)) u_key_ss (
      .clk_i   (clk1),
      .rst_ni  (rst_s_n),
      .key_n_i (btn_ss_n),
      .press_o (ss_p)
   );

   key_debounce #(.DEB_CYC(DEB_CYC)) u_key_clr (
      .clk_i   (clk1),
      .rst_ni  (rst_s_n),
      .key_n_i (btn_clr_n),
      .press_o (clr_p)
   );

   // FSM state register.
   always_ff @(posedge clk1 or negedge rst_s_n) begin
      if (!rst_s_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: clear outranks start/stop except while running.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (clr_p)     state_d = IDLE;
            else if (ss_p) state_d = RUN;
         end
         RUN: begin
            if (ss_p) state_d = PAUSE;
         end
         PAUSE: begin
            if (clr_p)     state_d = IDLE;
            else if (ss_p) state_d = RUN;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: datapath controls and the next value of the run flag.
   always_comb begin
      clear_all  = clr_p && (state_q != RUN);
      presc_zero = (state_q == IDLE) && ss_p && !clr_p;
      count_en   = (state_q == RUN);
      run_d      = (state_d == RUN);
   end

   // Prescaler next value: counts only in RUN, holds otherwise, zeroed on start.
   always_comb begin
      presc_d = presc_q;
      tick    = 1'b0;
      if (presc_zero) begin
         presc_d = '0;
      end else if (count_en) begin
         if (presc_q == PRESC_LAST) begin
            tick    = 1'b1;
            presc_d = '0;
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end
   end

   // Digit chain next value: ripple decimal carry; carry out of d3 sets ovf.
   always_comb begin
      digits_d = digits_q;
      ovf_d    = ovf_q;
      carry    = 1'b0;
      if (clear_all) begin
         digits_d = '0;
         ovf_d    = 1'b0;
      end else if (tick) begin
         carry = 1'b1;
         for (int unsigned i = 0; i < NDIG; i++) begin
            if (carry) begin
               {carry, digits_d[i]} = bcd_inc(digits_q[i]);
            end
         end
         if (carry) begin
            ovf_d = 1'b1;
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk1 or negedge rst_s_n) begin
      if (!rst_s_n) begin
         presc_q  <= '0;
         digits_q <= '0;
         ovf_q    <= 1'b0;
         run_q    <= 1'b0;
      end else begin
         presc_q  <= presc_d;
         digits_q <= digits_d;
         ovf_q    <= ovf_d;
         run_q    <= run_d;
      end
   end

   // Display select: sel 0 picks the most significant digit.
   always_comb begin
      case (sel)
         2'd0:    digit_out = digits_q[3];
         2'd1:    digit_out = digits_q[2];
         2'd2:    digit_out = digits_q[1];
         default: digit_out = digits_q[0];
      endcase
   end

   assign bcd_out = digits_q;
   assign run     = run_q;
   assign ovf     = ovf_q;

endmodule
